// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive deframer.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_AVG   = 2;

  localparam int PKT_WIDTH_DFLT = 16;
  localparam int FRAME_BCLK     = 32;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Bit-level front end: WS edge detection, SD deserialisation and slot length tracking.
module i2s_slot_shifter
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_WIDTH_DFLT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ws_i,
  input  logic                 sd_i,
  output logic [PKT_WIDTH-1:0] word_o,
  output logic                 isEdge_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 good_o,
  output logic                 overrun_o
);

  localparam int CNT_W = $clog2(PKT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                 wsD_q;
  logic [PKT_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    shift_d   = {shift_q[PKT_WIDTH-2:0], sd_i};
    word_o    = shift_d;
    isEdge_o  = (ws_i != wsD_q);
    rise_o    = ~wsD_q & ws_i;
    fall_o    = wsD_q & ~ws_i;
    good_o    = (cnt_q == CNT_MAX);
    overrun_o = ~isEdge_o & (cnt_q == CNT_MAX);
    // Counter parks at the slot length so a stuck WS cannot wrap it into a false good slot.
    cnt_d = cnt_q;
    if (isEdge_o) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wsD_q   <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      wsD_q   <= ws_i;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/i2s_rx_deframer.sv
// I2S slave receiver: framing FSM, mono channel selection and framing-error accounting.
module i2s_rx_deframer
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_WIDTH_DFLT,
  parameter int CHAN_SEL  = CH_LEFT,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ws_i,
  input  logic                 sd_i,
  output logic [PKT_WIDTH-1:0] pkt_o,
  output logic                 pktChanged_o,
  output logic [PKT_WIDTH-1:0] pktL_o,
  output logic [PKT_WIDTH-1:0] pktR_o,
  output logic                 locked_o,
  output logic                 frameErr_o,
  output logic [ERR_CNT_W-1:0] errCnt_o
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  logic [PKT_WIDTH-1:0] word;
  logic                 isEdge, rise, fall, good, overrun;

  i2s_slot_shifter #(.PKT_WIDTH(PKT_WIDTH)) u_shifter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ws_i      (ws_i),
    .sd_i      (sd_i),
    .word_o    (word),
    .isEdge_o  (isEdge),
    .rise_o    (rise),
    .fall_o    (fall),
    .good_o    (good),
    .overrun_o (overrun)
  );

  state_t               state_q, state_d;
  logic [PKT_WIDTH-1:0] pkt_q, pkt_d, pktL_q, pktL_d, pktR_q, pktR_d;
  logic                 strobe_q, strobe_d, err_q, err_d;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  logic [PKT_WIDTH:0]   avgSum;
  logic [PKT_WIDTH-1:0] monoSample;
  logic                 fault;

  // The right word completes this cycle; the left word was latched at the preceding rise.
  always_comb begin
    avgSum = {pktL_q[PKT_WIDTH-1], pktL_q} + {word[PKT_WIDTH-1], word};
    case (CHAN_SEL)
      CH_RIGHT: monoSample = word;
      CH_AVG:   monoSample = avgSum[PKT_WIDTH:1];
      default:  monoSample = pktL_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    pktL_d   = pktL_q;
    pktR_d   = pktR_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    errCnt_d = errCnt_q;
    fault    = 1'b0;
    case (state_q)
      SYNC: begin
        if (fall) state_d = LEFT;
      end
      LEFT: begin
        if (rise) begin
          if (good) begin
            pktL_d  = word;
            state_d = RIGHT;
          end else begin
            fault = 1'b1;
          end
        end else if (overrun) begin
          fault = 1'b1;
        end
      end
      RIGHT: begin
        if (fall) begin
          if (good) begin
            pktR_d   = word;
            pkt_d    = monoSample;
            strobe_d = 1'b1;
            state_d  = LEFT;
          end else begin
            fault = 1'b1;
          end
        end else if (overrun) begin
          fault = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
    if (fault) begin
      err_d   = 1'b1;
      state_d = SYNC;
      if (errCnt_q != '1) errCnt_d = errCnt_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SYNC;
      pkt_q    <= '0;
      pktL_q   <= '0;
      pktR_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      pktL_q   <= pktL_d;
      pktR_q   <= pktR_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign pkt_o        = pkt_q;
  assign pktChanged_o = strobe_q;
  assign pktL_o       = pktL_q;
  assign pktR_o       = pktR_q;
  assign locked_o     = (state_q != SYNC);
  assign frameErr_o   = err_q;
  assign errCnt_o     = errCnt_q;

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// Directed bench for i2s_rx_deframer: left, right and average instances share one I2S stream.
module tb_i2s_rx_deframer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ws  = 1'b1;
  logic sd  = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] lPkt, lPktL, lPktR, rPkt, rPktL, rPktR, aPkt, aPktL, aPktR;
  logic        lChg, lLock, lErr, rChg, rLock, rErr, aChg, aLock, aErr;
  logic [7:0]  lErrCnt, rErrCnt, aErrCnt;

  i2s_rx_deframer #(.PKT_WIDTH(16), .CHAN_SEL(0), .ERR_CNT_W(8)) dutL (
    .clk_i(clk), .rst_i(rst), .ws_i(ws), .sd_i(sd),
    .pkt_o(lPkt), .pktChanged_o(lChg), .pktL_o(lPktL), .pktR_o(lPktR),
    .locked_o(lLock), .frameErr_o(lErr), .errCnt_o(lErrCnt)
  );

  i2s_rx_deframer #(.PKT_WIDTH(16), .CHAN_SEL(1), .ERR_CNT_W(8)) dutR (
    .clk_i(clk), .rst_i(rst), .ws_i(ws), .sd_i(sd),
    .pkt_o(rPkt), .pktChanged_o(rChg), .pktL_o(rPktL), .pktR_o(rPktR),
    .locked_o(rLock), .frameErr_o(rErr), .errCnt_o(rErrCnt)
  );

  i2s_rx_deframer #(.PKT_WIDTH(16), .CHAN_SEL(2), .ERR_CNT_W(8)) dutA (
    .clk_i(clk), .rst_i(rst), .ws_i(ws), .sd_i(sd),
    .pkt_o(aPkt), .pktChanged_o(aChg), .pktL_o(aPktL), .pktR_o(aPktR),
    .locked_o(aLock), .frameErr_o(aErr), .errCnt_o(aErrCnt)
  );

  int assertCnt = 0;
  int failCnt   = 0;

  // Observed strobe and error-pulse cycles of the left-select instance.
  int strobeCnt   = 0;
  int errPulseCnt = 0;
  always @(negedge clk) begin
    if (lChg === 1'b1) strobeCnt++;
    if (lErr === 1'b1) errPulseCnt++;
  end

  logic        lastBit = 1'b0;
  logic        slotStartChg, frameStartChg;
  logic [15:0] slotStartPktL, slotStartPktR, slotStartPktA;
  logic [15:0] frameStartPktL, frameStartPktR, frameStartPktA;
  int          strobeBase, errBase;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WS slot of len BCLKs; SD carries the previous slot's LSB first, then word MSB-first.
  task automatic applyStimulus(input logic wsVal, input logic [15:0] word, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rst = 1'b0;
      ws  = wsVal;
      if (i == 0)       sd = lastBit;
      else if (i <= 15) sd = word[16-i];
      else              sd = 1'b0;
      @(posedge clk);
      #1;
      if (i == 0) begin
        slotStartChg  = lChg;
        slotStartPktL = lPkt;
        slotStartPktR = rPkt;
        slotStartPktA = aPkt;
      end
    end
    lastBit = word[0];
  endtask

  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
    applyStimulus(1'b0, l, 16);
    frameStartChg  = slotStartChg;
    frameStartPktL = slotStartPktL;
    frameStartPktR = slotStartPktR;
    frameStartPktA = slotStartPktA;
    applyStimulus(1'b1, r, 16);
  endtask

  task automatic resetCycle();
    @(negedge clk);
    rst = 1'b1;
    ws  = 1'b1;
    sd  = 1'b0;
    lastBit = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pkt"},    {16'h0, lPkt},  32'h0);
    checkOutput({tag, "_pktL"},   {16'h0, lPktL}, 32'h0);
    checkOutput({tag, "_pktR"},   {16'h0, lPktR}, 32'h0);
    checkOutput({tag, "_chg"},    {31'h0, lChg},  32'h0);
    checkOutput({tag, "_lock"},   {31'h0, lLock}, 32'h0);
    checkOutput({tag, "_err"},    {31'h0, lErr},  32'h0);
    checkOutput({tag, "_errCnt"}, {24'h0, lErrCnt}, 32'h0);
    checkOutput({tag, "_aPkt"},   {16'h0, aPkt},  32'h0);
  endtask

  initial begin
    $display("[TB] start");

    resetCycle();
    resetCycle();
    resetCycle();
    checkResetState("rst");

    // Aligned frames, left select; strobe first at the second fall.
    strobeBase = strobeCnt;
    errBase    = errPulseCnt;
    sendFrame(16'h1234, 16'hABCD);
    checkOutput("f1_noStrobe", strobeCnt - strobeBase, 0);
    checkOutput("f1_locked", {31'h0, lLock}, 32'h1);
    sendFrame(16'h1234, 16'hABCD);
    checkOutput("f2_startStrobe", {31'h0, frameStartChg}, 32'h1);
    checkOutput("f2_startPkt", {16'h0, frameStartPktL}, 32'h1234);
    for (int f = 0; f < 3; f++) sendFrame(16'h1234, 16'hABCD);
    checkOutput("f5_strobes", strobeCnt - strobeBase, 4);
    checkOutput("f5_pkt", {16'h0, lPkt}, 32'h1234);
    checkOutput("f5_pktL", {16'h0, lPktL}, 32'h1234);
    checkOutput("f5_pktR", {16'h0, lPktR}, 32'hABCD);
    checkOutput("f5_rPkt", {16'h0, rPkt}, 32'hABCD);
    checkOutput("f5_chgLow", {31'h0, lChg}, 32'h0);
    checkOutput("f5_noErr", errPulseCnt - errBase, 0);
    checkOutput("f5_errCnt", {24'h0, lErrCnt}, 32'h0);

    // Signed average cases, each observed at the fall that completes its right word.
    sendFrame(16'h7FFF, 16'h7FFF);
    checkOutput("avg_1234_ABCD", {16'h0, frameStartPktA}, 32'hDF00);
    sendFrame(16'h8000, 16'h0000);
    checkOutput("avg_7FFF_7FFF", {16'h0, frameStartPktA}, 32'h7FFF);
    sendFrame(16'hFFFF, 16'h0001);
    checkOutput("avg_8000_0000", {16'h0, frameStartPktA}, 32'hC000);
    sendFrame(16'h1234, 16'hABCD);
    checkOutput("avg_FFFF_0001", {16'h0, frameStartPktA}, 32'h0000);
    checkOutput("right_FFFF_0001", {16'h0, frameStartPktR}, 32'h0001);

    // Short left slot: WS rises after 15 BCLK.
    errBase = errPulseCnt;
    applyStimulus(1'b0, 16'h1234, 15);
    strobeBase = strobeCnt;
    applyStimulus(1'b1, 16'hABCD, 16);
    checkOutput("short_errPulse", errPulseCnt - errBase, 1);
    checkOutput("short_errCnt", {24'h0, lErrCnt}, 32'h1);
    checkOutput("short_unlocked", {31'h0, lLock}, 32'h0);
    checkOutput("short_noStrobe", strobeCnt - strobeBase, 0);
    checkOutput("short_pktHeld", {16'h0, lPkt}, 32'h1234);
    sendFrame(16'h5555, 16'h0F0F);
    checkOutput("resync_locked", {31'h0, lLock}, 32'h1);
    checkOutput("resync_noStrobe", strobeCnt - strobeBase, 0);
    sendFrame(16'h5555, 16'h0F0F);
    checkOutput("resync_strobe", {31'h0, frameStartChg}, 32'h1);
    checkOutput("resync_pkt", {16'h0, frameStartPktL}, 32'h5555);
    checkOutput("resync_pktR", {16'h0, lPktR}, 32'h0F0F);

    // WS stuck low for 40 BCLK: one overrun, then quiet in SYNC.
    errBase    = errPulseCnt;
    strobeBase = strobeCnt;
    applyStimulus(1'b0, 16'h9999, 40);
    checkOutput("stuck_errPulse", errPulseCnt - errBase, 1);
    checkOutput("stuck_errCnt", {24'h0, lErrCnt}, 32'h2);
    checkOutput("stuck_unlocked", {31'h0, lLock}, 32'h0);
    checkOutput("stuck_strobes", strobeCnt - strobeBase, 1);
    applyStimulus(1'b1, 16'h0000, 16);
    sendFrame(16'h1111, 16'h2222);
    checkOutput("stuck_relock", {31'h0, lLock}, 32'h1);
    sendFrame(16'h1111, 16'h2222);
    checkOutput("stuck_strobe", {31'h0, frameStartChg}, 32'h1);
    checkOutput("stuck_pkt", {16'h0, frameStartPktL}, 32'h1111);
    checkOutput("stuck_errCntHeld", {24'h0, lErrCnt}, 32'h2);

    // Reset in the middle of a right slot.
    applyStimulus(1'b0, 16'h3333, 16);
    applyStimulus(1'b1, 16'h4444, 8);
    resetCycle();
    checkResetState("midRst");
    strobeBase = strobeCnt;
    applyStimulus(1'b1, 16'h4444, 7);
    sendFrame(16'h6666, 16'h7777);
    checkOutput("midRst_noStrobe", strobeCnt - strobeBase, 0);
    checkOutput("midRst_locked", {31'h0, lLock}, 32'h1);
    sendFrame(16'h6666, 16'h7777);
    checkOutput("midRst_strobe", {31'h0, frameStartChg}, 32'h1);
    checkOutput("midRst_pkt", {16'h0, frameStartPktL}, 32'h6666);

    // 300 frames with a short left slot; counter must stop at all-ones.
    errBase    = errPulseCnt;
    strobeBase = strobeCnt;
    for (int f = 0; f < 254; f++) begin
      applyStimulus(1'b0, 16'h0000, 15);
      applyStimulus(1'b1, 16'h0000, 16);
    end
    checkOutput("sat_254", {24'h0, lErrCnt}, 32'hFE);
    applyStimulus(1'b0, 16'h0000, 15);
    applyStimulus(1'b1, 16'h0000, 16);
    checkOutput("sat_255", {24'h0, lErrCnt}, 32'hFF);
    for (int f = 0; f < 45; f++) begin
      applyStimulus(1'b0, 16'h0000, 15);
      applyStimulus(1'b1, 16'h0000, 16);
    end
    checkOutput("sat_300", {24'h0, lErrCnt}, 32'hFF);
    checkOutput("sat_pulses", errPulseCnt - errBase, 300);
    checkOutput("sat_strobes", strobeCnt - strobeBase, 1);
    checkOutput("sat_pktHeld", {16'h0, lPkt}, 32'h6666);
    checkOutput("sat_pktRHeld", {16'h0, lPktR}, 32'h7777);
    checkOutput("sat_unlocked", {31'h0, lLock}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
